sseg_display_ctrl: RTL and testbench
====================================

Name: sseg_display_ctrl

Overview:
- Downstream consumer of the 16-bit up/down count register. Shows the 16-bit value as four hex digits on a common-anode, time-multiplexed 7-segment display (Nexys-class board).
- Contains:
  - a refresh prescaler,
  - a 4-state digit-scan sequencer,
  - a frame-synchronous snapshot register, so digits never tear mid-frame,
  - registered active-low anode and segment drivers.

Parameters:
- REFRESH_DIV, 50000: clk cycles per digit slot. 100 MHz gives 2 kHz per digit and 500 Hz per frame. Legal range 2..2^24.
- CNT_W, 24: prescaler width. Must satisfy 2^CNT_W >= REFRESH_DIV.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- value  input  16  binary value to display. Sampled only at frame boundaries.
- an  output  4  digit enables, active-low. an[0] = rightmost digit (value[3:0]).
- seg  output  7  segment drives, active-low, ordered {g,f,e,d,c,b,a}.
- dp  output  1  decimal point, active-low. Held 1 (off).
- frame_start  output  1  one-cycle pulse when digit 0 is re-selected and snapshot reloads.

Behaviour:
- Interface rule: one clock; reset is synchronous and active-high (ports clk, rst). rst has priority over every other action.
- Reset state:
  - prescaler = 0, sel = 0, snapshot = 16'h0000.
  - an = 4'b1111, seg = 7'b1111111, dp = 1, frame_start = 0.
- Prescaler:
  - Counts 0..REFRESH_DIV-1, then wraps to 0.
  - tick = (prescaler == REFRESH_DIV-1). tick is an internal single-cycle strobe.
- Scan FSM states, one per digit: DIG0, DIG1, DIG2, DIG3.
  - On tick: DIG0 -> DIG1 -> DIG2 -> DIG3 -> DIG0.
  - Without tick, the state holds.
  - Reset enters DIG0.
- Snapshot:
  - On tick while in DIG3, snapshot <= value and frame_start <= 1 on the next clock. frame_start is 0 otherwise.
  - value changes between frame boundaries have no visible effect until the next boundary.
- Output register, updated every cycle when not in reset:
  - an <= one-cold code of the current state: DIG0 = 4'b1110, DIG1 = 4'b1101, DIG2 = 4'b1011, DIG3 = 4'b0111.
  - seg <= hex pattern of snapshot[4*sel+3 : 4*sel].
  - Latency: an and seg follow a state change by exactly 1 clk.
  - The first cycle after rst deasserts shows an = 1110 with the "0" pattern.
- Hex patterns {g..a}, active-low:
  - 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000
  - 4 = 0011001, 5 = 0010010, 6 = 0000010, 7 = 1111000
  - 8 = 0000000, 9 = 0010000, A = 0001000, b = 0000011
  - C = 1000110, d = 0100001, E = 0000110, F = 0001110
- Boundaries:
  - value = 16'hFFFF and 16'h0000 display normally.
  - Counter wrap-around upstream needs no special handling.
  - rst mid-frame returns to DIG0 and clears snapshot on that same edge.
- No glitch-blanking interval. Anode switching and segment switching occur on the same edge.

Optional Feature:
- Macro: SSEG_LEADING_ZERO_BLANK_EN.
- Defined:
  - Digits 3..1 are blanked while they and every higher digit of snapshot are zero. Blanking forces that digit's an bit to 1 and seg to 7'b1111111.
  - Digit 0 is always lit.
  - Example: 16'h002F shows "2F" only. 16'h0000 shows "0".
- Undefined: all four digits are always lit, with leading zeros shown.

Decomposition:
- Package sseg_pkg:
  - constants NUM_DIGITS = 4, SEG_BLANK = 7'b1111111, AN_OFF = 4'b1111;
  - the 16-entry hex pattern table;
  - a 2-bit digit-select typedef with the DIG0..DIG3 encodings.
- Sub-module hex_to_sseg: purely combinational, 4-bit nibble in, 7-bit active-low pattern out. Reused by other display blocks.
- Prescaler, FSM and snapshot stay in sseg_display_ctrl.

Test Plan (REFRESH_DIV = 4):
1. Reset: hold rst 3 cycles with value = 16'h1234 -> an = 1111, seg = 1111111, dp = 1, frame_start = 0. First post-reset cycle: an = 1110, seg = 1000000.
2. Scan order: value = 16'h1A2F held, run 2 frames -> after the first frame_start, an cycles 1110, 1101, 1011, 0111 at 4 clk each. seg follows F = 0001110, 2 = 0100100, A = 0001000, 1 = 1111001. Check 1-clk output latency.
3. Snapshot integrity: change value from 16'h1111 to 16'h2222 while in DIG1 -> the remaining digits of that frame still show "1". "2" appears only after the next frame_start pulse.
4. All patterns: step value through 16'h0123, 16'h4567, 16'h89AB, 16'hCDEF -> every nibble matches the table exactly.
5. Mid-frame reset: assert rst for 1 cycle in DIG2 -> the next cycle shows reset outputs, then an = 1110 and the "0" pattern. snapshot = 0 until the next frame boundary.
6. With SSEG_LEADING_ZERO_BLANK_EN defined:
   - value = 16'h002F -> DIG3 and DIG2 slots give an = 1111 and seg blank; DIG1 = "2"; DIG0 = "F".
   - value = 16'h0000 -> only DIG0 is lit, showing "0".

Source files
------------

// File: rtl/sseg_pkg.sv
// -----------------------------------------------------------------------------
// sseg_pkg
// Shared constants, digit-select encodings and the active-low hex segment table
// for the time-multiplexed 4-digit common-anode 7-segment display blocks.
// Segment bit order everywhere is {g,f,e,d,c,b,a}; a 0 lights a segment.
// -----------------------------------------------------------------------------
package sseg_pkg;

    localparam int         NUM_DIGITS = 4;
    localparam logic [6:0] SEG_BLANK  = 7'b1111111;
    localparam logic [3:0] AN_OFF     = 4'b1111;

    // Digit-select / scan-state encoding. DIG0 is the rightmost digit.
    typedef logic [1:0] dig_sel_t;
    localparam dig_sel_t DIG0 = 2'd0;
    localparam dig_sel_t DIG1 = 2'd1;
    localparam dig_sel_t DIG2 = 2'd2;
    localparam dig_sel_t DIG3 = 2'd3;

    // Active-low hex patterns, entry N is the pattern for nibble N.
    localparam logic [15:0][6:0] HEX_TABLE = {
        7'b0001110,  // F
        7'b0000110,  // E
        7'b0100001,  // d
        7'b1000110,  // C
        7'b0000011,  // b
        7'b0001000,  // A
        7'b0010000,  // 9
        7'b0000000,  // 8
        7'b1111000,  // 7
        7'b0000010,  // 6
        7'b0010010,  // 5
        7'b0011001,  // 4
        7'b0110000,  // 3
        7'b0100100,  // 2
        7'b1111001,  // 1
        7'b1000000   // 0
    };

    // One-cold anode code for a selected digit.
    function automatic logic [3:0] anode_code(input dig_sel_t sel);
        logic [3:0] code;
        case (sel)
            DIG0:    code = 4'b1110;
            DIG1:    code = 4'b1101;
            DIG2:    code = 4'b1011;
            default: code = 4'b0111;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/sseg_display_ctrl_if.sv
// -----------------------------------------------------------------------------
// sseg_display_ctrl_if
// Bundles the value input and display-side outputs of sseg_display_ctrl.
//   value       : 16-bit binary value to show (producer -> display block)
//   an          : active-low digit enables, an[0] = rightmost digit
//   seg         : active-low segments {g,f,e,d,c,b,a}
//   dp          : active-low decimal point (held off)
//   frame_start : one-cycle pulse when digit 0 is re-selected
//   dbg_state   : current scan state, for observation only
// Modports: master = value producer / display observer, slave = display block.
// -----------------------------------------------------------------------------
interface sseg_display_ctrl_if;
    import sseg_pkg::*;

    logic [15:0] value;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_start;
    dig_sel_t    dbg_state;

    modport master (
        output value,
        input  an, seg, dp, frame_start, dbg_state
    );

    modport slave (
        input  value,
        output an, seg, dp, frame_start, dbg_state
    );

endinterface

// File: rtl/sseg_hex_to_sseg.sv
// -----------------------------------------------------------------------------
// hex_to_sseg
// Purely combinational nibble to active-low 7-segment pattern decoder.
//   nibble : 4-bit hex digit in
//   seg_n  : 7-bit pattern out, {g,f,e,d,c,b,a}, 0 = segment lit
// -----------------------------------------------------------------------------
module hex_to_sseg
    import sseg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg_n
);

    assign seg_n = HEX_TABLE[nibble];

endmodule

// File: rtl/sseg_display_ctrl.sv
// -----------------------------------------------------------------------------
// sseg_display_ctrl
// Shows a 16-bit value as four hex digits on a common-anode, time-multiplexed
// 7-segment display. A prescaler produces one tick every REFRESH_DIV clocks;
// each tick advances the digit-scan state DIG0->DIG1->DIG2->DIG3->DIG0. The
// displayed value is captured into a snapshot only at the DIG3->DIG0 frame
// boundary so a frame never mixes digits from two different values.
// Anode and segment outputs are registered and follow the scan state by 1 clk.
//
// Ports:
//   clk         : system clock, posedge
//   rst         : synchronous active-high reset, highest priority
//   value       : value to display, sampled at frame boundaries only
//   an          : active-low digit enables, an[0] = rightmost digit
//   seg         : active-low segments {g,f,e,d,c,b,a}
//   dp          : active-low decimal point, held 1 (off)
//   frame_start : one-cycle pulse when digit 0 is re-selected / snapshot reloads
//   dbg_state   : current scan state (observation only)
//
// Build option: define SSEG_LEADING_ZERO_BLANK_EN to blank leading zero digits
// 3..1 (digit 0 always lit). Undefined, all four digits are always lit.
// -----------------------------------------------------------------------------
module sseg_display_ctrl
    import sseg_pkg::*;
#(
    parameter int REFRESH_DIV = 50000,
    parameter int CNT_W       = 24
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] value,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        frame_start,
    output dig_sel_t    dbg_state
);

    localparam logic [CNT_W-1:0] PRESC_LAST = CNT_W'(REFRESH_DIV - 1);

    logic [CNT_W-1:0] presc_q, presc_d;
    dig_sel_t         sel_q, sel_d;
    logic [15:0]      snap_q, snap_d;
    logic             fs_q, fs_d;
    logic [3:0]       an_q, an_d;
    logic [6:0]       seg_q, seg_d;

    logic             tick;
    logic             boundary;
    logic             blank;
    logic [3:0]       cur_nibble;
    logic [6:0]       cur_pat;

    hex_to_sseg u_hex (
        .nibble (cur_nibble),
        .seg_n  (cur_pat)
    );

    always_comb begin
        tick     = (presc_q == PRESC_LAST);
        presc_d  = tick ? '0 : presc_q + CNT_W'(1);

        // 2-bit state wraps DIG3 -> DIG0 naturally.
        sel_d    = tick ? sel_q + 2'd1 : sel_q;

        // Frame boundary: leaving DIG3. Snapshot and pulse share this edge.
        boundary = tick && (sel_q == DIG3);
        snap_d   = boundary ? value : snap_q;
        fs_d     = boundary;

        case (sel_q)
            DIG0:    cur_nibble = snap_q[3:0];
            DIG1:    cur_nibble = snap_q[7:4];
            DIG2:    cur_nibble = snap_q[11:8];
            default: cur_nibble = snap_q[15:12];
        endcase

`ifdef SSEG_LEADING_ZERO_BLANK_EN
        // A digit is a leading zero when it and every higher digit are zero.
        case (sel_q)
            DIG1:    blank = (snap_q[15:4]  == 12'h000);
            DIG2:    blank = (snap_q[15:8]  == 8'h00);
            DIG3:    blank = (snap_q[15:12] == 4'h0);
            default: blank = 1'b0;
        endcase
`else
        blank = 1'b0;
`endif

        an_d  = blank ? AN_OFF    : anode_code(sel_q);
        seg_d = blank ? SEG_BLANK : cur_pat;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q <= '0;
            sel_q   <= DIG0;
            snap_q  <= 16'h0000;
            fs_q    <= 1'b0;
            an_q    <= AN_OFF;
            seg_q   <= SEG_BLANK;
        end else begin
            presc_q <= presc_d;
            sel_q   <= sel_d;
            snap_q  <= snap_d;
            fs_q    <= fs_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
        end
    end

    assign an          = an_q;
    assign seg         = seg_q;
    assign dp          = 1'b1;
    assign frame_start = fs_q;
    assign dbg_state   = sel_q;

endmodule

// File: tb/tb_sseg_display_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sseg_display_ctrl
// Directed bench for sseg_display_ctrl with REFRESH_DIV = 4. Expected digit
// patterns come from a hand-written copy of the hex table below.
// -----------------------------------------------------------------------------
module tb_sseg_display_ctrl;
    import sseg_pkg::*;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    sseg_display_ctrl_if dif ();

    sseg_display_ctrl #(
        .REFRESH_DIV (4),
        .CNT_W       (3)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .value       (dif.value),
        .an          (dif.an),
        .seg         (dif.seg),
        .dp          (dif.dp),
        .frame_start (dif.frame_start),
        .dbg_state   (dif.dbg_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- expected-value helpers ----------------
    function automatic logic [6:0] exp_hex(input logic [3:0] n);
        logic [6:0] p;
        case (n)
            4'h0: p = 7'b1000000;
            4'h1: p = 7'b1111001;
            4'h2: p = 7'b0100100;
            4'h3: p = 7'b0110000;
            4'h4: p = 7'b0011001;
            4'h5: p = 7'b0010010;
            4'h6: p = 7'b0000010;
            4'h7: p = 7'b1111000;
            4'h8: p = 7'b0000000;
            4'h9: p = 7'b0010000;
            4'hA: p = 7'b0001000;
            4'hB: p = 7'b0000011;
            4'hC: p = 7'b1000110;
            4'hD: p = 7'b0100001;
            4'hE: p = 7'b0000110;
            default: p = 7'b0001110;
        endcase
        return p;
    endfunction

    function automatic logic exp_blank(input logic [15:0] v, input int d);
`ifdef SSEG_LEADING_ZERO_BLANK_EN
        return (d != 0) && ((v >> (4 * d)) == 16'h0000);
`else
        return (v == 16'hFFFF) && (d < 0);
`endif
    endfunction

    function automatic logic [3:0] exp_an(input logic [15:0] v, input int d);
        logic [3:0] one_cold [4];
        one_cold[0] = 4'b1110;
        one_cold[1] = 4'b1101;
        one_cold[2] = 4'b1011;
        one_cold[3] = 4'b0111;
        return exp_blank(v, d) ? 4'b1111 : one_cold[d];
    endfunction

    function automatic logic [6:0] exp_seg(input logic [15:0] v, input int d);
        logic [3:0] nib;
        nib = 4'((v >> (4 * d)) & 16'h000F);
        return exp_blank(v, d) ? 7'b1111111 : exp_hex(nib);
    endfunction

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Steps until the frame_start pulse is seen, bounded.
    task automatic wait_fs();
        logic found;
        found = 1'b0;
        for (int i = 0; i < 64; i++) begin
            step();
            if (dif.frame_start === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
        chk("wait_frame_start", 16'(found), 16'h0001);
    endtask

    // Called right after the edge that loaded the snapshot (or the reset edge).
    // Checks all 16 cycles of one frame; optionally changes value mid-frame.
    task automatic check_frame(input logic [15:0] v, input logic [15:0] chg_val,
                               input int chg_at);
        int k;
        for (int d = 0; d < 4; d++) begin
            for (int c = 0; c < 4; c++) begin
                step();
                k = d * 4 + c + 1;
                if (d * 4 + c == chg_at) dif.value = chg_val;
                chk($sformatf("an v=%h d=%0d c=%0d", v, d, c), 16'(dif.an), 16'(exp_an(v, d)));
                chk($sformatf("seg v=%h d=%0d c=%0d", v, d, c), 16'(dif.seg), 16'(exp_seg(v, d)));
                chk($sformatf("fs v=%h k=%0d", v, k), 16'(dif.frame_start), 16'(k == 16));
                chk($sformatf("state v=%h k=%0d", v, k), 16'(dif.dbg_state), 16'((k / 4) % 4));
                chk("dp", 16'(dif.dp), 16'h0001);
            end
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [15:0] pat_vals [4];
        logic        hit;
        checks   = 0;
        failures = 0;
        pat_vals[0] = 16'h0123;
        pat_vals[1] = 16'h4567;
        pat_vals[2] = 16'h89AB;
        pat_vals[3] = 16'hCDEF;

        // 1. Reset
        rst       = 1'b1;
        dif.value = 16'h1234;
        step();
        step();
        step();
        chk("rst an", 16'(dif.an), 16'h000F);
        chk("rst seg", 16'(dif.seg), 16'h007F);
        chk("rst dp", 16'(dif.dp), 16'h0001);
        chk("rst fs", 16'(dif.frame_start), 16'h0000);
        chk("rst state", 16'(dif.dbg_state), 16'h0000);
        rst = 1'b0;
        check_frame(16'h0000, 16'h0000, -1);
        check_frame(16'h1234, 16'h0000, -1);

        // 2. Scan order, two frames of 1A2F
        dif.value = 16'h1A2F;
        wait_fs();
        // Output latency: state already DIG0 while outputs still show DIG3.
        chk("lat state", 16'(dif.dbg_state), 16'h0000);
        chk("lat an", 16'(dif.an), 16'h0007);
        chk("lat seg", 16'(dif.seg), 16'(exp_hex(4'h1)));
        check_frame(16'h1A2F, 16'h0000, -1);
        check_frame(16'h1A2F, 16'h0000, -1);

        // 3. Snapshot integrity: change to 2222 during DIG1
        dif.value = 16'h1111;
        wait_fs();
        check_frame(16'h1111, 16'h2222, 5);
        check_frame(16'h2222, 16'h0000, -1);

        // 4. All hex patterns
        for (int i = 0; i < 4; i++) begin
            dif.value = pat_vals[i];
            wait_fs();
            check_frame(pat_vals[i], 16'h0000, -1);
        end

        // 5. Mid-frame reset in DIG2 (value CDEF still applied)
        hit = 1'b0;
        for (int i = 0; i < 32; i++) begin
            step();
            if (dif.dbg_state === DIG2) begin
                hit = 1'b1;
                break;
            end
        end
        chk("reach DIG2", 16'(hit), 16'h0001);
        rst = 1'b1;
        step();
        chk("mid rst an", 16'(dif.an), 16'h000F);
        chk("mid rst seg", 16'(dif.seg), 16'h007F);
        chk("mid rst fs", 16'(dif.frame_start), 16'h0000);
        chk("mid rst state", 16'(dif.dbg_state), 16'h0000);
        rst = 1'b0;
        check_frame(16'h0000, 16'h0000, -1);
        check_frame(16'hCDEF, 16'h0000, -1);

        // 6. Leading-zero cases and extremes
        dif.value = 16'h002F;
        wait_fs();
        check_frame(16'h002F, 16'h0000, -1);
        dif.value = 16'h0000;
        wait_fs();
        check_frame(16'h0000, 16'h0000, -1);
        dif.value = 16'hFFFF;
        wait_fs();
        check_frame(16'hFFFF, 16'h0000, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
